// File: rtl/timer_entry_ctrl_if.sv
// Keypad, counter-chain and status signals of the microwave timer entry controller.
// Latency: none; this file holds wiring only.
// Backpressure: none; every signal is a strobe or a level.
// master: the controller itself (takes keypad/timer_zero, drives digits and controls).
// slave : the surroundings (keypad drives strobes, counter chain reports timer_zero).
interface timer_entry_ctrl_if;
  logic       key_valid;   // one-cycle keypad strobe
  logic [3:0] key_digit;   // pressed digit, legal 0-9
  logic       start;       // one-cycle start/pause/resume strobe
  logic       cancel;      // one-cycle abort strobe
  logic       timer_zero;  // AND of the counter chain's zero outputs
  logic [3:0] min_ones;    // setpoint minutes digit
  logic [3:0] sec_tens;    // setpoint seconds-tens digit
  logic [3:0] sec_ones;    // setpoint seconds-ones digit
  logic       loadn;       // active-low load to the counter chain
  logic       enable;      // count enable to the counter chain
  logic       running;     // high while counting down
  logic       done;        // beeper
  logic       key_error;   // one-cycle pulse on a rejected event

  modport master (
    input  key_valid, key_digit, start, cancel, timer_zero,
    output min_ones, sec_tens, sec_ones, loadn, enable, running, done, key_error
  );

  modport slave (
    output key_valid, key_digit, start, cancel, timer_zero,
    input  min_ones, sec_tens, sec_ones, loadn, enable, running, done, key_error
  );
endinterface

// File: rtl/timer_entry_ctrl.sv
// Keypad M:SS time entry plus load/run/pause/done control of a down-counter chain.
// Latency: one cycle from a sampled strobe to the updated digits/state; outputs registered.
// Backpressure: none; strobes are acted on or dropped in the cycle they arrive.
// Ports: clock, clear (async active-high reset), bus (timer_entry_ctrl_if.master):
//   keypad strobes and timer_zero in; setpoint digits, loadn, enable, running, done,
//   key_error out.
module timer_entry_ctrl #(
  parameter int BEEP_CYCLES = 4
) (
  input  logic               clock,
  input  logic               clear,
  timer_entry_ctrl_if.master bus
);

  // Beep counter runs 0..BEEP_CYCLES-1 while in DONE.
  localparam int BW = (BEEP_CYCLES < 2) ? 1 : $clog2(BEEP_CYCLES);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          err_q, err_d;
  logic          wipe;
  logic          key_ok;
  logic          setpoint_zero;

  // A press is legal only while a further shift keeps seconds-tens at 0-5.
  assign key_ok        = (bus.key_digit <= 4'd9) && (cnt_q < 2'd3) && (ones_q <= 4'd5);
  assign setpoint_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_ENTRY;
      min_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      beep_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    err_d   = 1'b0;
    wipe    = 1'b0;

    // Within each state the if-chain order encodes cancel > start > key_valid.
    case (state_q)
      S_ENTRY: begin
        if (bus.cancel) begin
          wipe = 1'b1;
        end else if (bus.start) begin
          if (setpoint_zero) err_d = 1'b1;
          else               state_d = S_LOAD;
        end else if (bus.key_valid) begin
          if (key_ok) begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = bus.key_digit;
            cnt_d  = cnt_q + 2'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // Completion outranks cancel so a finished cook always beeps.
        if (bus.timer_zero) begin
          state_d = S_DONE;
          beep_d  = '0;
        end else if (bus.cancel) begin
          state_d = S_ENTRY;
          wipe    = 1'b1;
        end else if (bus.start) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.cancel) begin
          state_d = S_ENTRY;
          wipe    = 1'b1;
        end else if (bus.start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.cancel || (beep_q == BEEP_LAST)) begin
          state_d = S_ENTRY;
          wipe    = 1'b1;
        end else begin
          beep_d = beep_q + 1'b1;
        end
      end
      default: begin
        state_d = S_ENTRY;
        wipe    = 1'b1;
      end
    endcase

    if (wipe) begin
      min_d  = '0;
      tens_d = '0;
      ones_d = '0;
      cnt_d  = '0;
    end
  end

  assign bus.min_ones  = min_q;
  assign bus.sec_tens  = tens_q;
  assign bus.sec_ones  = ones_q;
  assign bus.loadn     = (state_q != S_LOAD);
  assign bus.enable    = (state_q == S_RUN);
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.key_error = err_q;

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Bench for timer_entry_ctrl: directed scenarios then random strobes, checked every
// cycle against a queue-based model of the entry rules and a seconds-count model of
// the downstream counter chain.
module tb_timer_entry_ctrl;

  localparam int BEEP = 4;
  localparam int MD_ENTRY = 0, MD_LOAD = 1, MD_RUN = 2, MD_PAUSE = 3, MD_DONE = 4;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  timer_entry_ctrl_if bus ();

  timer_entry_ctrl #(.BEEP_CYCLES(BEEP)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: entered digits as a queue (newest last), plain mode number.
  int m_mode;
  int q[$];
  bit m_err;
  int beep_left;
  int rem;  // counter chain contents in seconds

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dig(int k);
    if (q.size() > k) return q[q.size() - 1 - k];
    return 0;
  endfunction

  function automatic int setpoint();
    return dig(2) * 60 + dig(1) * 10 + dig(0);
  endfunction

  task automatic model_reset();
    m_mode = MD_ENTRY;
    q.delete();
    m_err = 1'b0;
    beep_left = 0;
  endtask

  task automatic to_entry();
    m_mode = MD_ENTRY;
    q.delete();
  endtask

  task automatic model_step(bit kv, logic [3:0] kd, bit st, bit cn, bit tz);
    m_err = 1'b0;
    case (m_mode)
      MD_ENTRY: begin
        if (cn) q.delete();
        else if (st) begin
          if (setpoint() == 0) m_err = 1'b1;
          else m_mode = MD_LOAD;
        end else if (kv) begin
          if (int'(kd) <= 9 && q.size() < 3 && dig(0) <= 5) q.push_back(int'(kd));
          else m_err = 1'b1;
        end
      end
      MD_LOAD: m_mode = MD_RUN;
      MD_RUN: begin
        if (tz) begin
          m_mode = MD_DONE;
          beep_left = BEEP;
        end else if (cn) to_entry();
        else if (st) m_mode = MD_PAUSE;
      end
      MD_PAUSE: begin
        if (cn) to_entry();
        else if (st) m_mode = MD_RUN;
      end
      default: begin
        if (cn) to_entry();
        else begin
          beep_left--;
          if (beep_left == 0) to_entry();
        end
      end
    endcase
  endtask

  task automatic compare_all(string pre);
    logic [11:0] ed;
    logic [4:0]  ec;
    ed = {4'(dig(2)), 4'(dig(1)), 4'(dig(0))};
    ec = {m_mode != MD_LOAD, m_mode == MD_RUN, m_mode == MD_RUN, m_mode == MD_DONE, m_err};
    chk({pre, "_digits"}, 32'({bus.min_ones, bus.sec_tens, bus.sec_ones}), 32'(ed));
    chk({pre, "_ctrl"}, 32'({bus.loadn, bus.enable, bus.running, bus.done, bus.key_error}),
        32'(ec));
  endtask

  // Drive one cycle of strobes from a negedge, step models at the posedge, check at next negedge.
  task automatic step(bit kv, logic [3:0] kd, bit st, bit cn);
    logic ld, en;
    int   sp;
    bit   tz;
    tz = (rem == 0);
    bus.key_valid  = kv;
    bus.key_digit  = kd;
    bus.start      = st;
    bus.cancel     = cn;
    bus.timer_zero = tz;
    ld = bus.loadn;
    en = bus.enable;
    sp = int'(bus.min_ones) * 60 + int'(bus.sec_tens) * 10 + int'(bus.sec_ones);
    @(posedge clock);
    model_step(kv, kd, st, cn, tz);
    if (!ld) rem = sp;
    else if (en && rem > 0) rem--;
    @(negedge clock);
    compare_all("cyc");
  endtask

  task automatic key(logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_mode(int target, string tag);
    int n;
    n = 0;
    while (m_mode != target && n < 2000) begin
      idle(1);
      n++;
    end
    chk(tag, 32'(m_mode), 32'(target));
  endtask

  initial begin
    model_reset();
    rem = 0;
    clear = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.timer_zero = 1'b0;
    repeat (2) @(negedge clock);
    compare_all("reset");
    clear = 1'b0;
    idle(1);

    // 1,2,3 accepted; 4th key rejected
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); idle(1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    // 7 then 2 rejected; 12 rejected
    key(4'd7); key(4'd2); key(4'd12);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    // start with 0:00 rejected
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(1);
    // 0:05 runs to completion and beeps
    key(4'd5);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    wait_mode(MD_DONE, "reach_done");
    wait_mode(MD_ENTRY, "done_exit");
    // pause / resume / cancel in pause
    key(4'd1); key(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(3);
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(3);
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(2);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1); idle(1);
    // start and cancel together in RUN: cancel wins
    key(4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(3);
    step(1'b0, 4'd0, 1'b1, 1'b1); idle(1);
    // cancel during DONE
    key(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    wait_mode(MD_DONE, "reach_done2");
    idle(1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    // asynchronous clear mid-RUN
    key(4'd2); key(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0); idle(4);
    #2;
    clear = 1'b1;
    #1;
    model_reset();
    compare_all("aclr");
    @(negedge clock);
    compare_all("aclr_hold");
    clear = 1'b0;
    idle(1);

    // random strobes
    for (int i = 0; i < 5000; i++) begin
      step(($urandom % 100) < 30, 4'($urandom_range(0, 11)),
           ($urandom % 100) < 6, ($urandom % 1000) < 15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_entry_ctrl.md
# timer_entry_ctrl

Keypad time-entry and run controller for the microwave timer. It collects decimal digits into an M:SS setpoint and presents the setpoint on the digit data buses of the downstream down-counter chain (minutes, seconds-tens, seconds-ones). It pulses the chain's active-low load, then drives the count enable until the chain reports all-zero. It also handles start/pause/cancel and the end-of-cook indication.

## Interface
Parameters:
- BEEP_CYCLES, default 4: number of cycles `done` stays high after the countdown completes (must be ≥1).

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: `key_digit` holds a keypad press.
- key_digit  in  4  pressed digit; legal values are 0-9.
- start  in  1  one-cycle strobe: start, pause or resume.
- cancel  in  1  one-cycle strobe: abort and clear the entry.
- timer_zero  in  1  high when every counter in the chain reads 0 (AND of the counters' `zero` outputs).
- min_ones  out  4  minutes digit, 0-9, sent to the counter `data_in`.
- sec_tens  out  4  seconds-tens digit, 0-5.
- sec_ones  out  4  seconds-ones digit, 0-9.
- loadn  out  1  active-low load to the counter chain.
- enable  out  1  count enable to the counter chain.
- running  out  1  high in RUN.
- done  out  1  high in DONE (beeper).
- key_error  out  1  one-cycle pulse when an event is rejected.

## Operation
- States are ENTRY, LOAD, RUN, PAUSE and DONE. Reset state is ENTRY.
- Reset values: all digits 0, digit count 0, loadn=1, enable=0, running=0, done=0, key_error=0.
- Decoded outputs:
  - loadn=0 only in LOAD.
  - enable=1 only in RUN.
  - running=1 in RUN.
  - done=1 in DONE.
- Event priority when strobes coincide: cancel > start > key_valid. Lower-priority strobes in the same cycle are dropped silently, with no key_error.
- ENTRY, key_valid:
  - The press is accepted if key_digit ≤ 9, the digit count < 3, and the current sec_ones ≤ 5.
  - On accept, the digits shift left: min_ones ← sec_tens, sec_tens ← sec_ones, sec_ones ← key_digit. The digit count increments.
  - Otherwise the digits are unchanged and key_error pulses.
- ENTRY, start:
  - If all three digits are 0, stay in ENTRY and pulse key_error.
  - Otherwise go to LOAD.
- ENTRY, cancel: clear the digits and the digit count.
- LOAD: lasts exactly one cycle, then RUN unconditionally. timer_zero is ignored in LOAD.
- RUN:
  - timer_zero=1 → DONE.
  - Otherwise cancel → ENTRY with digits and count cleared.
  - Otherwise start → PAUSE.
  - key_valid is ignored.
- PAUSE:
  - start → RUN, with no reload.
  - cancel → ENTRY with digits and count cleared.
  - key_valid is ignored.
- DONE:
  - Held for BEEP_CYCLES cycles, then ENTRY with digits and count cleared.
  - cancel ends DONE immediately, going to ENTRY with digits and count cleared.
  - start and key_valid are ignored.
- The digit registers hold the setpoint through LOAD/RUN/PAUSE. They are never modified by the countdown.
- The beep counter is wide enough for BEEP_CYCLES and resets to 0 on each entry to DONE.

## Timing
- All outputs are registered state or decodes of state; there is no combinational path from inputs to outputs.
- key_valid sampled at edge N → digits updated and visible after edge N.
- key_error is asserted for exactly the one cycle after the edge that rejected the event.
- start at edge N in ENTRY (nonzero setpoint):
  - LOAD for the cycle after edge N, with loadn=0 and enable=0. The counters load at edge N+1.
  - RUN from edge N+1, with enable=1.
- timer_zero is first evaluated in RUN, one cycle after the load edge. At that point the counters already hold the setpoint.
- timer_zero high at edge M in RUN → DONE after edge M, with enable=0. That is one counter decrement of latency; the counter's wrap value is never used.
- DONE is high for exactly BEEP_CYCLES cycles when there is no cancel.
- Asynchronous clear mid-operation forces the reset values immediately, in any state. On release, the block is in ENTRY with empty digits.

## Test plan
- Reset, then keys 1,2,3 on separate cycles → min_ones=1, sec_tens=2, sec_ones=3, digit count 3. A fourth key 4 → rejected, key_error one cycle, digits unchanged.
- Keys 7 then 2 → rejected at the second key (sec_ones=7>5), key_error=1, digits 0:07. Key 12 in ENTRY → rejected.
- Start with 0:00 → key_error, stays in ENTRY. Enter 0:05, start at edge N → loadn=0 for exactly the cycle after N, enable=1 from edge N+1.
- Run 0:05 with the real counter chain → enable stays high until timer_zero. Then done is high for BEEP_CYCLES=4 cycles, then ENTRY with digits 0.
- In RUN, start → PAUSE, enable=0, counters frozen. start again → RUN with no loadn pulse. cancel in PAUSE → ENTRY, digits 0.
- start and cancel in the same cycle in RUN → ENTRY (cancel wins). Assert clear mid-RUN → enable=0 and loadn=1 immediately, digits 0.
